// File: rtl/time_of_day_counter_pkg.sv
// Shared time-of-day constants, field widths and H/M/S helpers.
// The date counter imports this package for the same constants.
package time_of_day_counter_pkg;

    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HOUR  = 60;
    localparam int SEC_PER_MIN   = 60;
    localparam int PRESET_HOUR   = 12;
    localparam int PRESET_MIN    = 0;
    localparam int PRESET_SEC    = 0;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] LAST_HOUR = HOUR_W'(HOURS_PER_DAY - 1);
    localparam logic [MIN_W-1:0]  LAST_MIN  = MIN_W'(MIN_PER_HOUR - 1);
    localparam logic [SEC_W-1:0]  LAST_SEC  = SEC_W'(SEC_PER_MIN - 1);

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } tod_t;

    localparam tod_t PRESET_TOD = '{
        hour:   HOUR_W'(PRESET_HOUR),
        minute: MIN_W'(PRESET_MIN),
        second: SEC_W'(PRESET_SEC)
    };

    function automatic logic hms_in_range(input logic [HOUR_W-1:0] h,
                                          input logic [MIN_W-1:0]  m,
                                          input logic [SEC_W-1:0]  s);
        return (h <= LAST_HOUR) && (m <= LAST_MIN) && (s <= LAST_SEC);
    endfunction

    // 23:59:59 is the only value whose successor is midnight
    function automatic logic tod_is_last(input tod_t t);
        return (t.hour == LAST_HOUR) && (t.minute == LAST_MIN) && (t.second == LAST_SEC);
    endfunction

    function automatic tod_t tod_advance(input tod_t t);
        tod_t n;
        n = t;
        if (t.second == LAST_SEC) begin
            n.second = '0;
            if (t.minute == LAST_MIN) begin
                n.minute = '0;
                n.hour   = (t.hour == LAST_HOUR) ? '0 : t.hour + 1'b1;
            end else begin
                n.minute = t.minute + 1'b1;
            end
        end else begin
            n.second = t.second + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/time_of_day_counter_tick_prescaler.sv
// Divides clk down to one tick per CLK_HZ enabled cycles.
// tick is combinational on the wrap; the caller decides whether it counts.
module tick_prescaler
    import time_of_day_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              PCNT_W    = $clog2(CLK_HZ);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_HZ - 1);

    logic [PCNT_W-1:0] pcnt;

    assign tick = en && (pcnt == PCNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == PCNT_LAST) ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// Binary H/M/S time-of-day counter with valid/ready set port, preset level
// and a registered one-cycle day_increment pulse at midnight.
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              preset,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic [SEC_W-1:0]  set_sec,
    output logic              set_err,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  minute,
    output logic [SEC_W-1:0]  second,
    output logic              sec_tick,
    output logic              day_increment
);

    tod_t tod;
    logic tick;
    logic accept;
    logic set_ok;
    logic load;
    logic clr;

    assign set_ready = !preset && !rst;
    assign accept    = set_valid && set_ready;
    assign set_ok    = hms_in_range(set_hour, set_min, set_sec);
    assign load      = accept && set_ok;
    // A valid load restarts the second so the next tick is a full period away
    assign clr       = preset || load;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tod           <= '0;
            sec_tick      <= 1'b0;
            day_increment <= 1'b0;
            set_err       <= 1'b0;
        end else if (preset) begin
            tod           <= PRESET_TOD;
            sec_tick      <= 1'b0;
            day_increment <= 1'b0;
            set_err       <= 1'b0;
        end else begin
            set_err <= accept && !set_ok;
            if (load) begin
                tod           <= '{hour: set_hour, minute: set_min, second: set_sec};
                sec_tick      <= 1'b0;
                day_increment <= 1'b0;
            end else if (tick) begin
                tod           <= tod_advance(tod);
                sec_tick      <= 1'b1;
                day_increment <= tod_is_last(tod);
            end else begin
                sec_tick      <= 1'b0;
                day_increment <= 1'b0;
            end
        end
    end

    assign hour   = tod.hour;
    assign minute = tod.minute;
    assign second = tod.second;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: directed scenarios then random
// traffic, checked against a seconds-of-day reference model.
module tb_time_of_day_counter;

    localparam int CLK_HZ  = 4;
    localparam int DAY_SEC = 86400;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       preset;
    logic       set_valid;
    logic       set_ready;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       sec_tick;
    logic       day_increment;

    time_of_day_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .preset        (preset),
        .set_valid     (set_valid),
        .set_ready     (set_ready),
        .set_hour      (set_hour),
        .set_min       (set_min),
        .set_sec       (set_sec),
        .set_err       (set_err),
        .hour          (hour),
        .minute        (minute),
        .second        (second),
        .sec_tick      (sec_tick),
        .day_increment (day_increment)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hour;
        int minute;
        int second;
        bit tick;
        bit dinc;
        bit err;
        bit ready;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int checks = 0;
    int fails  = 0;
    int dut_days = 0;
    int dut_errs = 0;

    // reference model: time as seconds since midnight, prescaler as a phase
    int m_tod   = 0;
    int m_phase = 0;
    bit m_tick  = 0;
    bit m_dinc  = 0;
    bit m_err   = 0;
    int m_days  = 0;
    int m_errs  = 0;

    function automatic void model_reset();
        m_tod = 0; m_phase = 0; m_tick = 0; m_dinc = 0; m_err = 0;
    endfunction

    function automatic void model_step(input int r, input int p, input int v,
                                       input int h, input int m, input int s);
        bit ok;
        bit wrap;
        m_tick = 0; m_dinc = 0; m_err = 0;
        if (p != 0) begin
            m_tod = 12 * 3600; m_phase = 0;
            return;
        end
        ok = (h < 24) && (m < 60) && (s < 60);
        if (v != 0 && !ok) begin
            m_err = 1; m_errs++;
        end
        if (v != 0 && ok) begin
            m_tod = h * 3600 + m * 60 + s; m_phase = 0;
            return;
        end
        if (r != 0) begin
            wrap    = (m_phase == CLK_HZ - 1);
            m_phase = (m_phase + 1) % CLK_HZ;
            if (wrap) begin
                m_tod  = (m_tod + 1) % DAY_SEC;
                m_tick = 1;
                m_dinc = (m_tod == 0);
                if (m_dinc) m_days++;
            end
        end
    endfunction

    task automatic check_zero(input string name);
        checks++;
        if (hour !== 5'd0 || minute !== 6'd0 || second !== 6'd0 || sec_tick !== 1'b0 ||
            day_increment !== 1'b0 || set_err !== 1'b0 || set_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s: got %0d:%0d:%0d tick=%b day=%b err=%b rdy=%b, all must be 0",
                     name, hour, minute, second, sec_tick, day_increment, set_err, set_ready);
        end
    endtask

    task automatic check_hms(input string name, input int h, input int m, input int s);
        @(negedge clk); #1;
        checks++;
        if (int'(hour) != h || int'(minute) != m || int'(second) != s) begin
            fails++;
            $display("FAIL %s: got %0d:%0d:%0d expected %0d:%0d:%0d",
                     name, hour, minute, second, h, m, s);
        end
    endtask

    task automatic check_val(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // One clock: drive inputs for the coming edge, queue what the DUT should
    // show before that edge, then advance the model across it.
    task automatic cycle(input int r, input int p, input int v,
                         input int h, input int m, input int s, input int pr);
        exp_t e;
        @(posedge clk); #1;
        run       = r[0];
        preset    = p[0];
        set_valid = v[0];
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        if (pr != 0) begin
            #1 rst = 1'b1;
            #1 check_zero("async_reset");
            rst = 1'b0;
            model_reset();
        end
        e.hour   = m_tod / 3600;
        e.minute = (m_tod / 60) % 60;
        e.second = m_tod % 60;
        e.tick   = m_tick;
        e.dinc   = m_dinc;
        e.err    = m_err;
        e.ready  = (p == 0);
        sbq.push_back(e);
        model_step(r, p, v, int'(set_hour), int'(set_min), int'(set_sec));
    endtask

    task automatic idle(input int r);
        cycle(r, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (int'(hour) != mon_e.hour || int'(minute) != mon_e.minute ||
                int'(second) != mon_e.second || sec_tick !== mon_e.tick ||
                day_increment !== mon_e.dinc || set_err !== mon_e.err ||
                set_ready !== mon_e.ready) begin
                fails++;
                $display("FAIL scoreboard t=%0t: got %0d:%0d:%0d tick=%b day=%b err=%b rdy=%b expected %0d:%0d:%0d tick=%b day=%b err=%b rdy=%b",
                         $time, hour, minute, second, sec_tick, day_increment, set_err, set_ready,
                         mon_e.hour, mon_e.minute, mon_e.second, mon_e.tick, mon_e.dinc,
                         mon_e.err, mon_e.ready);
            end
            if (day_increment === 1'b1) dut_days++;
            if (set_err === 1'b1) dut_errs++;
        end
    end

    initial begin
        int d0;
        int e0;
        int r, p, v, h, m, s;
        rst = 1'b1; run = 1'b0; preset = 1'b0; set_valid = 1'b0;
        set_hour = '0; set_min = '0; set_sec = '0;
        #12 check_zero("reset_state");
        #10 rst = 1'b0;

        // free run from reset: 75 seconds in 300 cycles
        repeat (300) idle(1);
        idle(0);
        check_hms("count_75s", 0, 1, 15);

        // midnight rollover
        d0 = dut_days;
        cycle(1, 0, 1, 23, 59, 58, 0);
        repeat (9) idle(1);
        check_hms("midnight", 0, 0, 0);
        repeat (4) idle(1);
        check_val("midnight_day_pulses", dut_days - d0, 1);

        // invalid sets leave time alone; loading 00:00:00 is not a rollover
        cycle(0, 0, 1, 10, 20, 30, 0);
        e0 = dut_errs;
        cycle(0, 0, 1, 24, 0, 0, 0);
        cycle(0, 0, 1, 12, 60, 0, 0);
        idle(0);
        check_hms("invalid_set_hold", 10, 20, 30);
        idle(0);
        check_val("invalid_set_errs", dut_errs - e0, 2);
        d0 = dut_days;
        cycle(0, 0, 1, 0, 0, 0, 0);
        repeat (3) idle(0);
        check_hms("set_midnight", 0, 0, 0);
        check_val("set_midnight_no_day", dut_days - d0, 0);

        // valid set on the exact tick cycle
        for (int i = 0; i < 16 && m_phase != CLK_HZ - 1; i++) idle(1);
        cycle(1, 0, 1, 5, 6, 7, 0);
        idle(1);
        check_hms("collision", 5, 6, 7);
        repeat (6) idle(1);

        // preset over 23:59:59, set requests ignored while it is held
        cycle(1, 0, 1, 23, 59, 59, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, (i % 3 == 0) ? 1 : 0, 1, 2, 3, 0);
        idle(1);
        check_hms("preset_value", 12, 0, 0);
        repeat (5) idle(1);
        repeat (20) idle(0);
        check_hms("run_low_frozen", 12, 0, 1);
        repeat (4) idle(1);

        // async reset with the prescaler part-way through a second
        for (int i = 0; i < 16 && m_phase != 2; i++) idle(1);
        cycle(1, 0, 0, 0, 0, 0, 1);
        repeat (8) idle(1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 9) != 0) ? 1 : 0;
            p = ($urandom_range(0, 49) == 0) ? 1 : 0;
            v = ($urandom_range(0, 9) == 0) ? 1 : 0;
            if ($urandom_range(0, 3) == 0) begin
                h = 23; m = 59; s = $urandom_range(50, 59);
            end else begin
                h = $urandom_range(0, 31); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
            end
            cycle(r, p, v, h, m, s, 0);
        end
        repeat (3) idle(0);
        @(negedge clk); #1;
        check_val("total_days", dut_days, m_days);
        check_val("total_errs", dut_errs, m_errs);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Synchronous time-of-day counter, directly upstream of the date counter. Divides the system clock to a 1 Hz tick, keeps hours/minutes/seconds in binary, and emits a single registered, glitch-free `day_increment` pulse on every 23:59:59 → 00:00:00 rollover. That pulse drives the date counter's `day_increment` edge input. Time can be loaded through a valid/ready set port or forced by a preset level.

## Interface
- `CLK_HZ`, default 50_000_000: system clock cycles per second. Must be ≥ 2.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `run` input, 1 bit: level. When high the prescaler advances; when low it holds.
- `preset` input, 1 bit: synchronous level. Forces 12:00:00 while high.
- `set_valid` input, 1 bit: set request.
- `set_ready` output, 1 bit: set port can accept a request.
- `set_hour` input, 5 bits: requested hour, legal range 0–23.
- `set_min` input, 6 bits: requested minute, legal range 0–59.
- `set_sec` input, 6 bits: requested second, legal range 0–59.
- `set_err` output, 1 bit: one-cycle pulse when an accepted request is out of range.
- `hour` output, 5 bits: current hour.
- `minute` output, 6 bits: current minute.
- `second` output, 6 bits: current second.
- `sec_tick` output, 1 bit: one-cycle pulse on each counted second.
- `day_increment` output, 1 bit: one-cycle registered pulse at midnight rollover.

## Operation
- Prescaler `pcnt` has width clog2(CLK_HZ).
  - When `run` is high it counts 0..CLK_HZ-1, then wraps to 0. The wrap edge is the tick event.
- Tick event behaviour:
  - `second`+1.
  - When `second` is 59: second=0, minute+1.
  - When `minute` is 59: minute=0, hour+1.
  - When `hour` is 23: hour=0.
- Midnight rollover: on the tick edge taking 23:59:59 → 00:00:00, `day_increment` is registered high for exactly one cycle.
- Set handshake:
  - `set_ready` = ~`preset`, driven combinationally from a registered-safe input. It is low while `rst` is high.
  - A request is accepted when `set_valid && set_ready`.
  - An accepted request with all fields in range loads the fields on the next edge and clears `pcnt` to 0.
  - An accepted request with any field out of range leaves the time unchanged and pulses `set_err` for one cycle.
  - A set never produces `day_increment`, including a load of 00:00:00.
  - Back-to-back requests are allowed on every cycle.
- Preset: while `preset` is high, time = 12:00:00 and `pcnt` = 0 on every edge. No `sec_tick` and no `day_increment` are produced.
- Priority, highest first: `rst` > `preset` > accepted set > tick.
  - A tick coincident with an accepted valid set is discarded.
  - A tick coincident with an invalid set still advances the time.
- `run` low: `pcnt` holds, and the set and preset paths remain functional.

## Timing
- Reset values: hour=0, minute=0, second=0, `pcnt`=0, `sec_tick`=0, `day_increment`=0, `set_err`=0.
- Tick edge:
  - `pcnt` goes CLK_HZ-1 → 0.
  - The time fields update on that same edge.
  - `sec_tick` is high for the following cycle.
- With `run` held high, `sec_tick` recurs exactly every CLK_HZ cycles.
- Set latency: request accepted at edge N → new time, or `set_err`, visible after edge N. The first tick after a valid set lands CLK_HZ cycles later.
- `day_increment` is a flop output, high for exactly one `clk` period, and coincident with `sec_tick` and the 00:00:00 value.
- Reset mid-count: all state is cleared immediately. After `rst` deasserts, counting restarts from `pcnt`=0.
- Preset falling: counting resumes, and the first tick arrives CLK_HZ cycles after the last edge with `preset` high.

## Structure
- Shared package constants: HOURS_PER_DAY=24, MIN_PER_HOUR=60, SEC_PER_MIN=60, PRESET_HOUR=12, PRESET_MIN=0, PRESET_SEC=0.
- Shared package field widths: HOUR_W=5, MIN_W=6, SEC_W=6. The date counter takes the same package for its constants.
- Sub-module `tick_prescaler`:
  - Parameter `CLK_HZ`.
  - Inputs `clk`, `rst`, `en`, `clr`.
  - Output `tick`, combinational on the wrap condition.
- The top holds the H/M/S registers, range check, priority mux and output flops.

## Test plan
- `CLK_HZ`=4 is used for simulation in all scenarios.
- **Reset and count:** deassert `rst` with `run`=1 → `sec_tick` every 4 cycles; after 4×75 cycles, time = 00:01:15.
- **Midnight rollover:** valid set to 23:59:58, then run → after 8 cycles, time = 00:00:00 and `day_increment` is exactly one 1-cycle pulse, coincident with `sec_tick`. The date counter model advances 1 day.
- **Invalid set:** set 24:00:00, then 12:60:00 → `set_err` pulses once each and the time is unchanged. Set 00:00:00 → no `day_increment`.
- **Collision:** `set_valid` for 05:06:07 on the exact tick cycle → time = 05:06:07 with no extra second, and `pcnt` = 0.
- **Preset and run:** hold `preset` for 10 cycles during 23:59:59 → 12:00:00, `set_ready`=0, no pulses; release → next tick after 4 cycles. `run`=0 for 20 cycles → time and `pcnt` frozen.
- **Async reset mid-count:** pulse `rst` between clock edges at `pcnt`=2 → all outputs 0 immediately, and the first tick comes 4 cycles after release.
